// File: rtl/uart_transmitter.sv
// APB slave that serialises one written byte as an 8N1 UART frame, LSB first.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       PCLK,
  input  logic       PENABLE,
  input  logic       PSEL2,
  input  logic [7:0] PADDR,
  input  logic       PWRITE,
  input  logic       PRESETn,
  input  logic [7:0] PWDATA,
  output logic       PREADY,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_t           state_r, state_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [2:0]       bit_r, bit_nx;
  logic [7:0]       data_r, data_nx;
  logic             serial_nx, done_nx, ready_nx;
  logic             accept_s;
  logic             unused_paddr_s;

  assign unused_paddr_s = ^PADDR;
  assign accept_s       = PSEL2 & PENABLE & PWRITE & PREADY;

  // State, bit-timing counter, bit index and latched byte
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 3'd0;
      data_r  <= 8'h00;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      bit_r   <= bit_nx;
      data_r  <= data_nx;
    end
  end

  // Next-state logic; the counter clears on every state change
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    bit_nx   = bit_r;
    data_nx  = data_r;
    case (state_r)
      IDLE: begin
        cnt_nx = CNT_ZERO;
        if (accept_s) begin
          state_nx = START;
          data_nx  = PWDATA;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_LAST) begin
          state_nx = DATA;
          cnt_nx   = CNT_ZERO;
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nx = CNT_ZERO;
          bit_nx = bit_r + 3'd1;
          if (bit_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            state_nx = DATA;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_r == CNT_LAST) begin
          state_nx = STOP;
          cnt_nx   = CNT_ZERO;
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          state_nx = CLEANUP;
          cnt_nx   = CNT_ZERO;
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      CLEANUP: begin
        state_nx = IDLE;
        cnt_nx   = CNT_ZERO;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = CNT_ZERO;
        bit_nx   = 3'd0;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so the registered pins line up with it
  always_comb begin
    serial_nx = 1'b1;
    done_nx   = 1'b0;
    ready_nx  = 1'b0;
    case (state_nx)
      IDLE:    ready_nx  = 1'b1;
      START:   serial_nx = 1'b0;
      DATA:    serial_nx = data_nx[bit_nx];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_nx = even_parity(data_nx);
`endif
      STOP:    done_nx   = (cnt_nx == CNT_LAST);
      CLEANUP: serial_nx = 1'b1;
      default: serial_nx = 1'b1;
    endcase
  end

  // Output registers; reset forces the line high immediately
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      o_Tx_Serial <= 1'b1;
      o_Tx_Done   <= 1'b0;
      PREADY      <= 1'b1;
    end else begin
      o_Tx_Serial <= serial_nx;
      o_Tx_Done   <= done_nx;
      PREADY      <= ready_nx;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: reset, continuous, single byte, busy stall,
// reset abort and (with UART_TX_PARITY_EN) parity frames.
`define CHECK(tag, obs, exp) \
  begin \
    tests++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_uart_transmitter;
  localparam int CPB = 87;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       PCLK = 1'b0;
  logic       PENABLE, PSEL2, PWRITE, PRESETn;
  logic [7:0] PADDR, PWDATA;
  logic       PREADY, o_Tx_Serial, o_Tx_Done;
  int         tests = 0;
  int         errors = 0;

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .PCLK(PCLK), .PENABLE(PENABLE), .PSEL2(PSEL2), .PADDR(PADDR),
    .PWRITE(PWRITE), .PRESETn(PRESETn), .PWDATA(PWDATA),
    .PREADY(PREADY), .o_Tx_Serial(o_Tx_Serial), .o_Tx_Done(o_Tx_Done)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive(input logic en, input logic [7:0] d);
    PSEL2 = en; PENABLE = en; PWRITE = en; PWDATA = d;
  endtask

  // Called one cycle after the accept edge; returns in the first cycle PREADY is back high.
  task automatic run_frame(input string tag, input logic [7:0] d,
                           input int stall_at, input logic [7:0] d2);
    logic [10:0] got, exp;
    int done_cnt, done_at, ready_hi;
    got = 11'd0; done_cnt = 0; done_at = -1; ready_hi = 0;
`ifdef UART_TX_PARITY_EN
    exp = {1'b1, ^d, d, 1'b0};
`else
    exp = {2'b01, d, 1'b0};
`endif
    `CHECK({tag, "_start_line"}, o_Tx_Serial, 1'b0)
    for (int n = 1; n <= FRAME + 2; n++) begin
      if (n == stall_at) drive(1'b1, d2);
      if (n % CPB == CPB / 2) got[n / CPB] = o_Tx_Serial;
      if (o_Tx_Done) begin done_cnt++; done_at = n; end
      if (n <= FRAME + 1 && PREADY) ready_hi++;
      if (n < FRAME + 2) tick();
    end
    `CHECK({tag, "_bits"}, got, exp)
    `CHECK({tag, "_done_count"}, done_cnt, 1)
    `CHECK({tag, "_done_time"}, done_at, FRAME)
    `CHECK({tag, "_busy_ready"}, ready_hi, 0)
    `CHECK({tag, "_ready_back"}, PREADY, 1'b1)
  endtask

  initial begin
    int bad;
    PADDR = 8'h7F;
    PRESETn = 1'b0;
    drive(1'b1, 8'hFF);
    // Reset held with a write presented: no frame, idle outputs
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_Tx_Serial !== 1'b1 || PREADY !== 1'b1 || o_Tx_Done !== 1'b0) bad++;
    end
    `CHECK("reset_hold", bad, 0)
    `CHECK("reset_line", o_Tx_Serial, 1'b1)
    `CHECK("reset_ready", PREADY, 1'b1)
    `CHECK("reset_done", o_Tx_Done, 1'b0)

    // Continuous: release with write held, back-to-back frames of 8'hFF
    PRESETn = 1'b1;
    tick();
    run_frame("cont0", 8'hFF, 0, 8'h00);
    tick();
    run_frame("cont1", 8'hFF, 0, 8'h00);
    tick();
    run_frame("cont2", 8'hFF, 0, 8'h00);
    drive(1'b0, 8'h00);
    tick();
    tick();
    `CHECK("idle_line", o_Tx_Serial, 1'b1)
    `CHECK("idle_ready", PREADY, 1'b1)

    // Single byte with the spec line pattern
    drive(1'b1, 8'hA5);
    tick();
    drive(1'b0, 8'h00);
    `CHECK("a5_ready_fall", PREADY, 1'b0)
    run_frame("a5", 8'hA5, 0, 8'h00);

    // Busy stall: second write held off until the first frame is done
    drive(1'b1, 8'h3C);
    tick();
    drive(1'b0, 8'h00);
    run_frame("stall1", 8'h3C, 300, 8'hFF);
    tick();
    drive(1'b0, 8'h00);
    run_frame("stall2", 8'hFF, 0, 8'h00);

    // Reset abort during data bit 3 of 8'h00
    drive(1'b1, 8'h00);
    tick();
    drive(1'b0, 8'h00);
    repeat (4 * CPB + 40) tick();
    `CHECK("abort_pre_line", o_Tx_Serial, 1'b0)
    PRESETn = 1'b0;
    #1;
    `CHECK("abort_line", o_Tx_Serial, 1'b1)
    `CHECK("abort_ready", PREADY, 1'b1)
    `CHECK("abort_done", o_Tx_Done, 1'b0)
    repeat (3) tick();
    PRESETn = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (o_Tx_Done !== 1'b0 || o_Tx_Serial !== 1'b1) bad++;
    end
    `CHECK("abort_quiet", bad, 0)

    // 8'h07: odd weight, parity bit 1 when enabled
    drive(1'b1, 8'h07);
    tick();
    drive(1'b0, 8'h00);
    run_frame("b07", 8'h07, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
